// File: rtl/sample_sched_pkg.sv
// Shared constants for the sensor sampling scheduler: grant-source codes,
// FSM state encoding and the fixed-priority source picker.
package sample_sched_pkg;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_PER  = 2'd1;
    localparam logic [1:0] SRC_BTN  = 2'd2;
    localparam logic [1:0] SRC_HOST = 2'd3;

    localparam int PEND_PER  = 0;
    localparam int PEND_BTN  = 1;
    localparam int PEND_HOST = 2;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    // Host beats button beats periodic; SRC_NONE when nothing is pending.
    function automatic logic [1:0] pick_src(input logic [2:0] pend);
        logic [1:0] src;
        src = SRC_NONE;
        if (pend[PEND_HOST]) begin
            src = SRC_HOST;
        end else if (pend[PEND_BTN]) begin
            src = SRC_BTN;
        end else if (pend[PEND_PER]) begin
            src = SRC_PER;
        end
        return src;
    endfunction

endpackage

// File: rtl/sample_sched_tick.sv
// Free-running periodic request generator; tick is high for the one cycle
// in which the counter sits at its last value, so the wrap edge sees it.
module sample_tick #(
    parameter int unsigned PERIOD_CYC = 50_000_000
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic tick
);

    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYC - 1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign tick = (cnt_q == PERIOD_LAST);

    always_comb begin
        cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_sched.sv
// Arbitrates periodic/button/host read requests onto the single sensor driver
// and enforces warm-up, minimum read spacing and the driver response timeout.
//
// state  | meaning
// WARMUP | sensor settling after reset; requests latched, none granted
// IDLE   | waiting for enable, driver free and a pending request
// WAIT   | driver read in flight; waiting for drv_done or timeout
// GAP    | enforced idle time after every transaction
module sample_sched
    import sample_sched_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 10_000_000,
    parameter int unsigned PERIOD_CYC  = 50_000_000,
    parameter int unsigned GAP_CYC     = 20_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req_btn,
    input  logic       req_host,
    input  logic       drv_busy,
    input  logic       drv_done,
    input  logic       drv_err,
    output logic       drv_start,
    output logic [1:0] grant_src,
    output logic       data_valid,
    output logic       data_err,
    output logic       timeout,
    output logic       sched_busy
);

    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    // CLK_HZ only documents the intended clock; a zero here means a bad build.
    if (CLK_HZ == 0 || GAP_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_params
        $error("sample_sched: CLK_HZ, GAP_CYC and TIMEOUT_CYC must be nonzero");
    end

    logic tick;

    sample_tick #(
        .PERIOD_CYC(PERIOD_CYC)
    ) u_tick (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .tick  (tick)
    );

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  pend_q, pend_d;
    logic [1:0]  grant_src_q, grant_src_d;
    logic        drv_start_q, drv_start_d;
    logic        data_valid_q, data_valid_d;
    logic        data_err_q, data_err_d;
    logic        timeout_q, timeout_d;
    logic        sched_busy_q, sched_busy_d;
    logic [2:0]  grant_clr;
    logic [1:0]  win_src;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        grant_src_d  = grant_src_q;
        drv_start_d  = 1'b0;
        data_valid_d = 1'b0;
        data_err_d   = 1'b0;
        timeout_d    = 1'b0;
        grant_clr    = 3'b000;
        win_src      = pick_src(pend_q);

        case (state_q)
            ST_WARMUP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_IDLE: begin
                if (enable && !drv_busy && (win_src != SRC_NONE)) begin
                    state_d     = ST_WAIT;
                    timer_d     = 32'd0;
                    drv_start_d = 1'b1;
                    grant_src_d = win_src;
                    case (win_src)
                        SRC_HOST: grant_clr[PEND_HOST] = 1'b1;
                        SRC_BTN:  grant_clr[PEND_BTN]  = 1'b1;
                        default:  grant_clr[PEND_PER]  = 1'b1;
                    endcase
                end
            end
            ST_WAIT: begin
                // A completion on the last timer cycle still counts as a result.
                if (drv_done) begin
                    state_d      = ST_GAP;
                    timer_d      = 32'd0;
                    data_valid_d = !drv_err;
                    data_err_d   = drv_err;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d   = ST_GAP;
                    timer_d   = 32'd0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d     = ST_IDLE;
                    timer_d     = 32'd0;
                    grant_src_d = SRC_NONE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_WARMUP;
                timer_d = 32'd0;
            end
        endcase

        // New requests are OR-ed after the clear so a same-cycle re-request survives.
        pend_d       = (pend_q & ~grant_clr) | {req_host, req_btn, tick};
        sched_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WARMUP;
            timer_q      <= 32'd0;
            pend_q       <= 3'b000;
            grant_src_q  <= SRC_NONE;
            drv_start_q  <= 1'b0;
            data_valid_q <= 1'b0;
            data_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            sched_busy_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
            grant_src_q  <= grant_src_d;
            drv_start_q  <= drv_start_d;
            data_valid_q <= data_valid_d;
            data_err_q   <= data_err_d;
            timeout_q    <= timeout_d;
            sched_busy_q <= sched_busy_d;
        end
    end

    assign drv_start  = drv_start_q;
    assign grant_src  = grant_src_q;
    assign data_valid = data_valid_q;
    assign data_err   = data_err_q;
    assign timeout    = timeout_q;
    assign sched_busy = sched_busy_q;

endmodule

// File: tb/tb_sample_sched.sv
// Directed bench for sample_sched with a deadline-based reference model
// compared every cycle, plus literal checks on the key event timings.
module tb_sample_sched;

    localparam int PER = 100;
    localparam int GAP = 20;
    localparam int TMO = 10;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       enable, req_btn, req_host, drv_busy, drv_done, drv_err;
    logic       drv_start, data_valid, data_err, timeout, sched_busy;
    logic [1:0] grant_src;

    sample_sched #(
        .CLK_HZ(10_000_000), .PERIOD_CYC(PER), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .req_btn(req_btn),
        .req_host(req_host), .drv_busy(drv_busy), .drv_done(drv_done),
        .drv_err(drv_err), .drv_start(drv_start), .grant_src(grant_src),
        .data_valid(data_valid), .data_err(data_err), .timeout(timeout),
        .sched_busy(sched_busy)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edges since reset release.
    int cyc = 0;
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model: phases expressed as deadlines on the edge count.
    int         e = 0;
    bit         in_txn = 0;
    int         t_start = 0;
    int         idle_at = GAP;
    bit         p_per = 0, p_btn = 0, p_host = 0;
    logic       m_start = 0, m_valid = 0, m_err = 0, m_to = 0;
    logic [1:0] m_src = 0;

    always @(posedge clk_in or negedge rst_n) begin
        bit g_per, g_btn, g_host;
        if (!rst_n) begin
            e = 0; in_txn = 0; t_start = 0; idle_at = GAP;
            p_per = 0; p_btn = 0; p_host = 0;
            m_start = 0; m_valid = 0; m_err = 0; m_to = 0; m_src = 0;
        end else begin
            e++;
            m_start = 0; m_valid = 0; m_err = 0; m_to = 0;
            g_per = 0; g_btn = 0; g_host = 0;
            if (in_txn) begin
                if (drv_done) begin
                    m_valid = !drv_err; m_err = drv_err; in_txn = 0; idle_at = e + GAP;
                end else if (e == t_start + TMO) begin
                    m_to = 1; in_txn = 0; idle_at = e + GAP;
                end
            end else if (e > idle_at && enable && !drv_busy) begin
                if (p_host)     begin g_host = 1; m_src = 2'd3; end
                else if (p_btn) begin g_btn = 1;  m_src = 2'd2; end
                else if (p_per) begin g_per = 1;  m_src = 2'd1; end
                if (g_host || g_btn || g_per) begin
                    m_start = 1; in_txn = 1; t_start = e;
                end
            end
            if (e == idle_at) m_src = 2'd0;
            p_host = (p_host && !g_host) || req_host;
            p_btn  = (p_btn && !g_btn) || req_btn;
            p_per  = (p_per && !g_per) || (e % PER == 0);
        end
    end

    always @(negedge clk_in) begin
        logic [6:0] got, exp;
        got = {drv_start, grant_src, data_valid, data_err, timeout, sched_busy};
        exp = {m_start, m_src, m_valid, m_err, m_to, (in_txn || e < idle_at)};
        chk("model_outputs", 32'(got), 32'(exp));
    end

    int n_start = 0, n_result = 0, n_to = 0;
    always @(negedge clk_in) begin
        if (drv_start) n_start++;
        if (data_valid || data_err) n_result++;
        if (timeout) n_to++;
    end

    task automatic wait_cyc(input int k);
        while (cyc != k) @(negedge clk_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; req_btn = 0; req_host = 0;
        drv_busy = 0; drv_done = 0; drv_err = 0;
        repeat (2) @(negedge clk_in);
        chk("reset_outputs", 32'({drv_start, grant_src, data_valid, data_err, timeout, sched_busy}), 32'h01);
        rst_n = 1'b1;

        // Warm-up: host request latched at edge 5, granted right after WARMUP.
        wait_cyc(4);  req_host = 1;
        wait_cyc(5);  req_host = 0;
        wait_cyc(20); chk("warmup_no_start", 32'(n_start), 0);
        chk("warmup_end_idle", 32'(sched_busy), 0);
        wait_cyc(21); chk("warm_grant_start", 32'(drv_start), 1);
        chk("warm_grant_src", 32'(grant_src), 3);
        wait_cyc(22); chk("start_one_cycle", 32'(drv_start), 0);
        wait_cyc(23); drv_done = 1;
        wait_cyc(24); drv_done = 0; chk("valid_pulse", 32'(data_valid), 1);
        wait_cyc(25); chk("valid_one_cycle", 32'(data_valid), 0);

        // Priority: simultaneous button and host.
        wait_cyc(50); req_btn = 1; req_host = 1;
        wait_cyc(51); req_btn = 0; req_host = 0;
        wait_cyc(52); chk("prio_first_start", 32'(drv_start), 1);
        chk("prio_first_src", 32'(grant_src), 3);
        wait_cyc(54); drv_done = 1; drv_err = 1;
        wait_cyc(55); drv_done = 0; drv_err = 0;
        chk("err_pulse", 32'(data_err), 1);
        chk("err_no_valid", 32'(data_valid), 0);
        wait_cyc(56); chk("err_one_cycle", 32'(data_err), 0);
        wait_cyc(75); chk("gap_src_cleared", 32'(grant_src), 0);
        chk("gap_spacing", 32'(n_start), 2);
        wait_cyc(76); chk("prio_second_start", 32'(drv_start), 1);
        chk("prio_second_src", 32'(grant_src), 2);
        wait_cyc(77); drv_done = 1;
        wait_cyc(78); drv_done = 0; chk("btn_valid", 32'(data_valid), 1);

        // Timeout: periodic request at edge 100, driver never answers.
        wait_cyc(101); chk("per_start", 32'(drv_start), 1);
        chk("per_src", 32'(grant_src), 1);
        wait_cyc(110); chk("timeout_not_early", 32'(timeout), 0);
        wait_cyc(111); chk("timeout_pulse", 32'(timeout), 1);
        wait_cyc(112); chk("timeout_one_cycle", 32'(timeout), 0);
        wait_cyc(114); drv_done = 1;
        wait_cyc(115); drv_done = 0;
        wait_cyc(116); chk("late_done_no_valid", 32'(data_valid), 0);
        wait_cyc(130); chk("late_done_ignored", 32'(n_result), 3);

        // Gating: periodic request at edge 200 held off by busy, then enable.
        wait_cyc(190); drv_busy = 1;
        wait_cyc(203); enable = 0;
        wait_cyc(205); drv_busy = 0;
        wait_cyc(208); chk("gated_no_start", 32'(n_start), 4);
        enable = 1;
        wait_cyc(209); chk("gated_grant_start", 32'(drv_start), 1);
        chk("gated_grant_src", 32'(grant_src), 1);

        // Reset in WAIT with a button request pending.
        wait_cyc(210); req_btn = 1;
        wait_cyc(211); req_btn = 0;
        wait_cyc(212); #2;
        rst_n = 0; drv_done = 1;
        #1;
        chk("wait_reset_outputs", 32'({drv_start, grant_src, data_valid, data_err, timeout, sched_busy}), 32'h01);
        repeat (3) @(negedge clk_in);
        #2;
        drv_done = 0; rst_n = 1;
        wait_cyc(1); drv_done = 1;
        wait_cyc(2); drv_done = 0;
        wait_cyc(21); chk("no_stale_grant", 32'(drv_start), 0);
        wait_cyc(40); chk("post_reset_starts", 32'(n_start), 5);
        chk("post_reset_results", 32'(n_result), 3);
        chk("post_reset_timeouts", 32'(n_to), 1);
        chk("post_reset_idle", 32'(sched_busy), 0);

        @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
